// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared types and constants for the flash config-port arbiter
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESP    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One requester's view of a config transaction, as captured at grant
    typedef struct packed {
        logic [1:0]  devsel;
        logic [13:0] addr;
        logic        wren;
        logic        rden;
        logic [31:0] wdata;
        logic        expand_enable;
        logic        expand_dir;
    } flsh_req_t;

endpackage

// File: rtl/flash_arb_watchdog.sv
// rtl/flash_arb_watchdog.sv - issue-to-completion watchdog counter
module flash_arb_watchdog #(
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // Expiry fires on the cycle the count would reach TIMEOUT_CYCLES, so the
    // forced completion lands exactly TIMEOUT_CYCLES cycles after issue.
    localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_CYCLES - 1'b1;

    logic [TIMEOUT_W-1:0] count;

    // Count cycles while a transaction is outstanding; clear between transactions
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/flash_cfg_arbiter.sv
// rtl/flash_cfg_arbiter.sv - round-robin arbiter for the shared flash config port
module flash_cfg_arbiter
    import flash_arb_pkg::*;
#(
    parameter int                   TIMEOUT_W      = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [1:0]  req0_devsel,
    input  logic [13:0] req0_addr,
    input  logic        req0_wren,
    input  logic        req0_rden,
    input  logic [31:0] req0_wdata,
    input  logic        req0_expand_enable,
    input  logic        req0_expand_dir,
    output logic [31:0] req0_rdata,
    output logic        req0_done,
    output logic [1:0]  req0_bresp,
    output logic [1:0]  req0_rresp,

    input  logic [1:0]  req1_devsel,
    input  logic [13:0] req1_addr,
    input  logic        req1_wren,
    input  logic        req1_rden,
    input  logic [31:0] req1_wdata,
    input  logic        req1_expand_enable,
    input  logic        req1_expand_dir,
    output logic [31:0] req1_rdata,
    output logic        req1_done,
    output logic [1:0]  req1_bresp,
    output logic [1:0]  req1_rresp,

    output logic [1:0]  cfg_flsh_devsel,
    output logic [13:0] cfg_flsh_addr,
    output logic        cfg_flsh_wren,
    output logic        cfg_flsh_rden,
    output logic [31:0] cfg_flsh_wdata,
    output logic        cfg_flsh_expand_enable,
    output logic        cfg_flsh_expand_dir,
    input  logic [31:0] flsh_cfg_rdata,
    input  logic        flsh_cfg_done,
    input  logic [1:0]  flsh_cfg_bresp,
    input  logic [1:0]  flsh_cfg_rresp,

    output logic        arb_owner,
    output logic        arb_busy,
    output logic        arb_timeout_err
);

    arb_state_t  state;
    logic        last_grant;
    flsh_req_t   cfg_q;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_bresp;
    logic [1:0]  rsp_rresp;

    flsh_req_t   req0_bus;
    flsh_req_t   req1_bus;
    flsh_req_t   sel_req;
    logic        active0;
    logic        active1;
    logic        grant;
    logic        owner_active;
    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expired;

    assign req0_bus = {req0_devsel, req0_addr, req0_wren, req0_rden, req0_wdata,
                       req0_expand_enable, req0_expand_dir};
    assign req1_bus = {req1_devsel, req1_addr, req1_wren, req1_rden, req1_wdata,
                       req1_expand_enable, req1_expand_dir};

    assign active0 = req0_wren | req0_rden;
    assign active1 = req1_wren | req1_rden;

    // On a tie the requester that was not served last wins; otherwise the lone requester
    assign grant        = (active0 && active1) ? ~last_grant : active1;
    assign sel_req      = grant ? req1_bus : req0_bus;
    assign owner_active = arb_owner ? active1 : active0;

    assign wd_clear  = (state == ST_IDLE);
    assign wd_enable = (state == ST_ISSUE);

    flash_arb_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Arbitration FSM: grant, issue, one-cycle response, wait for owner release
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            last_grant      <= 1'b1;
            arb_owner       <= 1'b0;
            cfg_q           <= '0;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_bresp       <= RESP_OKAY;
            rsp_rresp       <= RESP_OKAY;
            arb_timeout_err <= 1'b0;
        end else begin
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_bresp       <= RESP_OKAY;
            rsp_rresp       <= RESP_OKAY;
            arb_timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (active0 || active1) begin
                        arb_owner  <= grant;
                        last_grant <= grant;
                        cfg_q      <= sel_req;
                        if (sel_req.wren && sel_req.rden) begin
                            // Ambiguous command: never reaches the flash, answered locally
                            cfg_q.wren <= 1'b0;
                            cfg_q.rden <= 1'b0;
                            rsp_valid  <= 1'b1;
                            rsp_bresp  <= RESP_SLVERR;
                            rsp_rresp  <= RESP_SLVERR;
                            state      <= ST_RESP;
                        end else begin
                            state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (flsh_cfg_done) begin
                        cfg_q.wren <= 1'b0;
                        cfg_q.rden <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= flsh_cfg_rdata;
                        rsp_bresp  <= flsh_cfg_bresp;
                        rsp_rresp  <= flsh_cfg_rresp;
                        state      <= ST_RESP;
                    end else if (wd_expired) begin
                        cfg_q.wren      <= 1'b0;
                        cfg_q.rden      <= 1'b0;
                        rsp_valid       <= 1'b1;
                        rsp_bresp       <= RESP_SLVERR;
                        rsp_rresp       <= RESP_SLVERR;
                        arb_timeout_err <= 1'b1;
                        state           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    cfg_q.wren <= 1'b0;
                    cfg_q.rden <= 1'b0;
                    if (!owner_active) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_flsh_devsel        = cfg_q.devsel;
    assign cfg_flsh_addr          = cfg_q.addr;
    assign cfg_flsh_wren          = cfg_q.wren;
    assign cfg_flsh_rden          = cfg_q.rden;
    assign cfg_flsh_wdata         = cfg_q.wdata;
    assign cfg_flsh_expand_enable = cfg_q.expand_enable;
    assign cfg_flsh_expand_dir    = cfg_q.expand_dir;

    assign arb_busy = (state != ST_IDLE);

    // Response demux: only the owner ever sees a non-zero response
    assign req0_done  = rsp_valid & ~arb_owner;
    assign req1_done  = rsp_valid &  arb_owner;
    assign req0_rdata = req0_done ? rsp_rdata : '0;
    assign req0_bresp = req0_done ? rsp_bresp : '0;
    assign req0_rresp = req0_done ? rsp_rresp : '0;
    assign req1_rdata = req1_done ? rsp_rdata : '0;
    assign req1_bresp = req1_done ? rsp_bresp : '0;
    assign req1_rresp = req1_done ? rsp_rresp : '0;

endmodule

// File: tb/tb_flash_cfg_arbiter.sv
// tb/tb_flash_cfg_arbiter.sv - directed self-checking bench for flash_cfg_arbiter
module tb_flash_cfg_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req0_devsel, req1_devsel;
    logic [13:0] req0_addr, req1_addr;
    logic        req0_wren, req0_rden, req1_wren, req1_rden;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_expand_enable, req0_expand_dir, req1_expand_enable, req1_expand_dir;
    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_done, req1_done;
    logic [1:0]  req0_bresp, req0_rresp, req1_bresp, req1_rresp;
    logic [1:0]  cfg_flsh_devsel;
    logic [13:0] cfg_flsh_addr;
    logic        cfg_flsh_wren, cfg_flsh_rden;
    logic [31:0] cfg_flsh_wdata;
    logic        cfg_flsh_expand_enable, cfg_flsh_expand_dir;
    logic [31:0] flsh_cfg_rdata;
    logic        flsh_cfg_done;
    logic [1:0]  flsh_cfg_bresp, flsh_cfg_rresp;
    logic        arb_owner, arb_busy, arb_timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    flash_cfg_arbiter #(
        .TIMEOUT_W      (16),
        .TIMEOUT_CYCLES (16'd16)
    ) dut (
        .clock                  (clock),
        .reset                  (reset),
        .req0_devsel            (req0_devsel),
        .req0_addr              (req0_addr),
        .req0_wren              (req0_wren),
        .req0_rden              (req0_rden),
        .req0_wdata             (req0_wdata),
        .req0_expand_enable     (req0_expand_enable),
        .req0_expand_dir        (req0_expand_dir),
        .req0_rdata             (req0_rdata),
        .req0_done              (req0_done),
        .req0_bresp             (req0_bresp),
        .req0_rresp             (req0_rresp),
        .req1_devsel            (req1_devsel),
        .req1_addr              (req1_addr),
        .req1_wren              (req1_wren),
        .req1_rden              (req1_rden),
        .req1_wdata             (req1_wdata),
        .req1_expand_enable     (req1_expand_enable),
        .req1_expand_dir        (req1_expand_dir),
        .req1_rdata             (req1_rdata),
        .req1_done              (req1_done),
        .req1_bresp             (req1_bresp),
        .req1_rresp             (req1_rresp),
        .cfg_flsh_devsel        (cfg_flsh_devsel),
        .cfg_flsh_addr          (cfg_flsh_addr),
        .cfg_flsh_wren          (cfg_flsh_wren),
        .cfg_flsh_rden          (cfg_flsh_rden),
        .cfg_flsh_wdata         (cfg_flsh_wdata),
        .cfg_flsh_expand_enable (cfg_flsh_expand_enable),
        .cfg_flsh_expand_dir    (cfg_flsh_expand_dir),
        .flsh_cfg_rdata         (flsh_cfg_rdata),
        .flsh_cfg_done          (flsh_cfg_done),
        .flsh_cfg_bresp         (flsh_cfg_bresp),
        .flsh_cfg_rresp         (flsh_cfg_rresp),
        .arb_owner              (arb_owner),
        .arb_busy               (arb_busy),
        .arb_timeout_err        (arb_timeout_err)
    );

    typedef struct {
        int          who;
        logic        wr;
        logic        rd;
        logic [1:0]  devsel;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic        ee;
        logic        ed;
        int          lat;
        logic [31:0] f_rdata;
        logic [1:0]  f_bresp;
        logic [1:0]  f_rresp;
        logic        exp_wren;
        logic        exp_rden;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_bresp;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs[5];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] done_of(input int who);
        return (who == 0) ? 32'(req0_done) : 32'(req1_done);
    endfunction

    function automatic logic [31:0] rdata_of(input int who);
        return (who == 0) ? req0_rdata : req1_rdata;
    endfunction

    function automatic logic [31:0] bresp_of(input int who);
        return (who == 0) ? 32'(req0_bresp) : 32'(req1_bresp);
    endfunction

    function automatic logic [31:0] rresp_of(input int who);
        return (who == 0) ? 32'(req0_rresp) : 32'(req1_rresp);
    endfunction

    task automatic set_req(input int who, input logic wr, input logic rd, input logic [1:0] ds,
                           input logic [13:0] ad, input logic [31:0] wd, input logic ee,
                           input logic ed);
        if (who == 0) begin
            req0_wren = wr; req0_rden = rd; req0_devsel = ds; req0_addr = ad;
            req0_wdata = wd; req0_expand_enable = ee; req0_expand_dir = ed;
        end else begin
            req1_wren = wr; req1_rden = rd; req1_devsel = ds; req1_addr = ad;
            req1_wdata = wd; req1_expand_enable = ee; req1_expand_dir = ed;
        end
    endtask

    task automatic flash_done(input logic [31:0] rd, input logic [1:0] br, input logic [1:0] rr);
        flsh_cfg_rdata = rd; flsh_cfg_bresp = br; flsh_cfg_rresp = rr; flsh_cfg_done = 1'b1;
        tick;
        flsh_cfg_done = 1'b0; flsh_cfg_rdata = '0; flsh_cfg_bresp = '0; flsh_cfg_rresp = '0;
    endtask

    // One complete single-requester transaction with exact cycle timing
    task automatic do_txn(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        set_req(v.who, v.wr, v.rd, v.devsel, v.addr, v.wdata, v.ee, v.ed);
        tick;
        chk({tag, "_owner"}, 32'(arb_owner), 32'(v.who));
        chk({tag, "_busy"}, 32'(arb_busy), 32'd1);
        chk({tag, "_cfg_wren"}, 32'(cfg_flsh_wren), 32'(v.exp_wren));
        chk({tag, "_cfg_rden"}, 32'(cfg_flsh_rden), 32'(v.exp_rden));
        if (!(v.wr && v.rd)) begin
            chk({tag, "_cfg_addr"}, 32'(cfg_flsh_addr), 32'(v.addr));
            chk({tag, "_cfg_wdata"}, cfg_flsh_wdata, v.wdata);
            chk({tag, "_cfg_devsel"}, 32'(cfg_flsh_devsel), 32'(v.devsel));
            chk({tag, "_cfg_expand"}, 32'({cfg_flsh_expand_enable, cfg_flsh_expand_dir}),
                32'({v.ee, v.ed}));
            for (int k = 1; k <= v.lat; k++) begin
                chk({tag, "_early_done"}, done_of(v.who), 32'd0);
                tick;
            end
            flash_done(v.f_rdata, v.f_bresp, v.f_rresp);
            chk({tag, "_cfg_drop"}, 32'({cfg_flsh_wren, cfg_flsh_rden}), 32'd0);
        end
        chk({tag, "_done"}, done_of(v.who), 32'd1);
        chk({tag, "_other_done"}, done_of(1 - v.who), 32'd0);
        chk({tag, "_other_rdata"}, rdata_of(1 - v.who), 32'd0);
        chk({tag, "_rdata"}, rdata_of(v.who), v.exp_rdata);
        chk({tag, "_bresp"}, bresp_of(v.who), 32'(v.exp_bresp));
        chk({tag, "_rresp"}, rresp_of(v.who), 32'(v.exp_rresp));
        set_req(v.who, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        tick;
        chk({tag, "_done_pulse"}, done_of(v.who), 32'd0);
        chk({tag, "_release_busy"}, 32'(arb_busy), 32'd1);
        tick;
        chk({tag, "_idle"}, 32'(arb_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{who: 0, wr: 1'b0, rd: 1'b1, devsel: 2'd1, addr: 14'h0010, wdata: 32'h0,
                    ee: 1'b0, ed: 1'b0, lat: 5, f_rdata: 32'hDEADBEEF, f_bresp: 2'b00,
                    f_rresp: 2'b00, exp_wren: 1'b0, exp_rden: 1'b1, exp_rdata: 32'hDEADBEEF,
                    exp_bresp: 2'b00, exp_rresp: 2'b00};
        vecs[1] = '{who: 1, wr: 1'b1, rd: 1'b0, devsel: 2'd3, addr: 14'h3FFF, wdata: 32'hA5A55A5A,
                    ee: 1'b1, ed: 1'b1, lat: 0, f_rdata: 32'h00001234, f_bresp: 2'b01,
                    f_rresp: 2'b00, exp_wren: 1'b1, exp_rden: 1'b0, exp_rdata: 32'h00001234,
                    exp_bresp: 2'b01, exp_rresp: 2'b00};
        vecs[2] = '{who: 1, wr: 1'b1, rd: 1'b1, devsel: 2'd2, addr: 14'h0100, wdata: 32'h11111111,
                    ee: 1'b0, ed: 1'b1, lat: 0, f_rdata: 32'h0, f_bresp: 2'b00,
                    f_rresp: 2'b00, exp_wren: 1'b0, exp_rden: 1'b0, exp_rdata: 32'h0,
                    exp_bresp: 2'b10, exp_rresp: 2'b10};
        vecs[3] = '{who: 0, wr: 1'b0, rd: 1'b1, devsel: 2'd0, addr: 14'h2AAA, wdata: 32'h0,
                    ee: 1'b1, ed: 1'b0, lat: 2, f_rdata: 32'hCAFEF00D, f_bresp: 2'b00,
                    f_rresp: 2'b10, exp_wren: 1'b0, exp_rden: 1'b1, exp_rdata: 32'hCAFEF00D,
                    exp_bresp: 2'b00, exp_rresp: 2'b10};
        vecs[4] = '{who: 0, wr: 1'b1, rd: 1'b0, devsel: 2'd2, addr: 14'h0000, wdata: 32'hFFFFFFFF,
                    ee: 1'b0, ed: 1'b1, lat: 1, f_rdata: 32'h0, f_bresp: 2'b11,
                    f_rresp: 2'b00, exp_wren: 1'b1, exp_rden: 1'b0, exp_rdata: 32'h0,
                    exp_bresp: 2'b11, exp_rresp: 2'b00};

        reset = 1'b1;
        set_req(0, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        flsh_cfg_done = 1'b0; flsh_cfg_rdata = '0; flsh_cfg_bresp = '0; flsh_cfg_rresp = '0;
        tick;
        tick;
        chk("rst_cfg_rw", 32'({cfg_flsh_wren, cfg_flsh_rden}), 32'd0);
        chk("rst_done", 32'({req0_done, req1_done}), 32'd0);
        chk("rst_owner", 32'(arb_owner), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_timeout", 32'(arb_timeout_err), 32'd0);
        chk("rst_cfg_addr", 32'(cfg_flsh_addr), 32'd0);
        reset = 1'b0;
        tick;

        // Table-driven single-requester transactions (incl. read latency and illegal command)
        for (int i = 0; i < 5; i++) begin
            do_txn(vecs[i], i);
        end

        // Simultaneous requests after reset: req0 first, then req1, then req0 again
        reset = 1'b1; tick; reset = 1'b0; tick;
        set_req(0, 1'b1, 1'b0, 2'd1, 14'h0005, 32'h00000A0A, 1'b0, 1'b0);
        set_req(1, 1'b1, 1'b0, 2'd2, 14'h0006, 32'h00000B0B, 1'b0, 1'b0);
        tick;
        chk("rr1_owner", 32'(arb_owner), 32'd0);
        chk("rr1_wdata", cfg_flsh_wdata, 32'h00000A0A);
        req0_addr = 14'h1234;
        tick;
        chk("rr1_addr_hold", 32'(cfg_flsh_addr), 32'h0005);
        flash_done(32'h0, 2'b00, 2'b00);
        chk("rr1_req0_done", 32'(req0_done), 32'd1);
        chk("rr1_req1_done", 32'(req1_done), 32'd0);
        set_req(0, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        tick;
        chk("rr1_release_wren", 32'(cfg_flsh_wren), 32'd0);
        tick;
        chk("rr1_gap_wren", 32'(cfg_flsh_wren), 32'd0);
        chk("rr1_gap_busy", 32'(arb_busy), 32'd0);
        tick;
        chk("rr2_owner", 32'(arb_owner), 32'd1);
        chk("rr2_wdata", cfg_flsh_wdata, 32'h00000B0B);
        chk("rr2_wren", 32'(cfg_flsh_wren), 32'd1);
        flash_done(32'h0, 2'b00, 2'b00);
        chk("rr2_req1_done", 32'(req1_done), 32'd1);
        chk("rr2_req0_done", 32'(req0_done), 32'd0);
        set_req(1, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        tick;
        tick;
        set_req(0, 1'b0, 1'b1, 2'd0, 14'h0007, 32'd0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b1, 2'd0, 14'h0008, 32'd0, 1'b0, 1'b0);
        tick;
        chk("rr3_owner", 32'(arb_owner), 32'd0);
        chk("rr3_addr", 32'(cfg_flsh_addr), 32'h0007);
        flash_done(32'h0, 2'b00, 2'b00);
        chk("rr3_req0_done", 32'(req0_done), 32'd1);
        set_req(0, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        set_req(1, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        tick;
        tick;
        chk("rr3_idle", 32'(arb_busy), 32'd0);

        // Watchdog: no flash done, forced SLVERR completion 16 cycles after issue
        set_req(0, 1'b0, 1'b1, 2'd1, 14'h0020, 32'd0, 1'b0, 1'b0);
        flsh_cfg_rdata = 32'h55AA55AA;
        tick;
        chk("to_issue_rden", 32'(cfg_flsh_rden), 32'd1);
        for (int k = 2; k <= 16; k++) begin
            tick;
            chk($sformatf("to_wait%0d_err", k), 32'(arb_timeout_err), 32'd0);
            chk($sformatf("to_wait%0d_rden", k), 32'(cfg_flsh_rden), 32'd1);
        end
        tick;
        chk("to_err", 32'(arb_timeout_err), 32'd1);
        chk("to_done", 32'(req0_done), 32'd1);
        chk("to_rdata", req0_rdata, 32'd0);
        chk("to_resp", 32'({req0_bresp, req0_rresp}), 32'hA);
        chk("to_rden_drop", 32'(cfg_flsh_rden), 32'd0);
        set_req(0, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        flsh_cfg_rdata = '0;
        tick;
        chk("to_err_pulse", 32'(arb_timeout_err), 32'd0);
        flsh_cfg_done = 1'b1;
        tick;
        chk("to_stray_done", 32'({req0_done, req1_done}), 32'd0);
        chk("to_stray_busy", 32'(arb_busy), 32'd0);
        flsh_cfg_done = 1'b0;
        tick;
        chk("to_stray_done2", 32'({req0_done, req1_done}), 32'd0);
        do_txn(vecs[1], 10);

        // Reset in the middle of an issued read
        set_req(1, 1'b0, 1'b1, 2'd0, 14'h0030, 32'd0, 1'b0, 1'b0);
        tick;
        chk("rm_rden", 32'(cfg_flsh_rden), 32'd1);
        tick;
        reset = 1'b1;
        tick;
        chk("rm_rden_drop", 32'(cfg_flsh_rden), 32'd0);
        chk("rm_busy", 32'(arb_busy), 32'd0);
        chk("rm_done", 32'({req0_done, req1_done}), 32'd0);
        reset = 1'b0;
        set_req(1, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("rm_quiet%0d", k), 32'({req0_done, req1_done, arb_busy}), 32'd0);
        end

        // Owner keeps rden asserted for 3 cycles after its done pulse
        set_req(0, 1'b0, 1'b1, 2'd0, 14'h0040, 32'd0, 1'b0, 1'b0);
        tick;
        flash_done(32'h00C0FFEE, 2'b00, 2'b00);
        chk("hold_done", 32'(req0_done), 32'd1);
        chk("hold_rdata", req0_rdata, 32'h00C0FFEE);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("hold%0d_busy", k), 32'(arb_busy), 32'd1);
            chk($sformatf("hold%0d_rden", k), 32'(cfg_flsh_rden), 32'd0);
            chk($sformatf("hold%0d_done", k), 32'(req0_done), 32'd0);
        end
        set_req(0, 1'b0, 1'b0, 2'd0, 14'd0, 32'd0, 1'b0, 1'b0);
        tick;
        chk("hold_idle", 32'(arb_busy), 32'd0);
        chk("hold_no_reissue", 32'(cfg_flsh_rden), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
